// File: rtl/riscv_pkg.sv
// Shared RV32I-subset definitions: opcodes, ALU/result encodings, immediate
// formats and the ID/EX control bundle.
package riscv_pkg;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIAlu   = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   localparam logic [1:0] ResultAlu = 2'b00;
   localparam logic [1:0] ResultMem = 2'b01;
   localparam logic [1:0] ResultPc4 = 2'b10;

   typedef enum logic [1:0] {ImmI, ImmS, ImmB, ImmJ} immsrc_e;

   typedef struct packed {
      logic       regwrite;
      logic [1:0] resultsrc;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       alusrc;
      logic [2:0] alucontrol;
      logic       illegal;
   } ctrl_t;

   // Returns {supported, alucontrol} for the funct3 values shared by R-type and I-ALU.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return {1'b1, AluAdd};
         3'b111:  return {1'b1, AluAnd};
         3'b110:  return {1'b1, AluOr};
         3'b010:  return {1'b1, AluSlt};
         default: return {1'b0, AluAdd};
      endcase
   endfunction

   function automatic logic [31:0] imm_ext(input logic [31:0] instr, input immsrc_e src);
      case (src)
         ImmI:    return {{20{instr[31]}}, instr[31:20]};
         ImmS:    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
         ImmB:    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                          1'b0};
      endcase
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two async read ports with same-cycle write bypass,
// one synchronous write port, synchronous active-low clear. Entry 0 reads as zero.
module register_file #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [4:0]      raddr1_i,
   input  logic [4:0]      raddr2_i,
   input  logic            we_i,
   input  logic [4:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != 5'd0);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass makes the read see the value being written this cycle.
   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      rdata2_o = regs_q[raddr2_i];
      if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
      if (wr_en && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
      if (raddr1_i == 5'd0) rdata1_o = '0;
      if (raddr2_i == 5'd0) rdata2_o = '0;
   end

endmodule

// File: rtl/decode_cycle.sv
// ID stage: decodes instrD, reads the register file, extends the immediate and
// registers the result into the ID/EX pipeline register.
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instrD,
   input  logic [XLEN-1:0] pcD,
   input  logic [XLEN-1:0] pcincr4D,
   input  logic            regwriteW,
   input  logic [4:0]      rdW,
   input  logic [XLEN-1:0] resultW,
   input  logic            flushE,
   output logic [4:0]      rs1D,
   output logic [4:0]      rs2D,
   output logic [XLEN-1:0] rd1E,
   output logic [XLEN-1:0] rd2E,
   output logic [XLEN-1:0] immextE,
   output logic [XLEN-1:0] pcE,
   output logic [XLEN-1:0] pcincr4E,
   output logic [4:0]      rs1E,
   output logic [4:0]      rs2E,
   output logic [4:0]      rdE,
   output logic            regwriteE,
   output logic [1:0]      resultsrcE,
   output logic            memwriteE,
   output logic            jumpE,
   output logic            branchE,
   output logic            alusrcE,
   output logic [2:0]      alucontrolE,
   output logic            illegalE
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [3:0]      alu_f3;
   logic            legal;
   immsrc_e         immsrc;
   ctrl_t           ctrl_d, ctrl_q;
   logic [XLEN-1:0] rd1_d, rd2_d, immext_d;
   logic [XLEN-1:0] rd1_q, rd2_q, immext_q, pc_q, pcincr4_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;

   assign opcode = instrD[6:0];
   assign funct3 = instrD[14:12];
   assign funct7 = instrD[31:25];
   assign rs1D   = instrD[19:15];
   assign rs2D   = instrD[24:20];
   assign alu_f3 = alu_from_funct3(funct3);

   register_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_register_file (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .raddr1_i (rs1D),
      .raddr2_i (rs2D),
      .we_i     (regwriteW),
      .waddr_i  (rdW),
      .wdata_i  (resultW),
      .rdata1_o (rd1_d),
      .rdata2_o (rd2_d)
   );

   always_comb begin
      ctrl_d = '0;
      immsrc = ImmI;
      legal  = 1'b1;
      unique case (opcode)
         OpLoad: begin
            legal              = (funct3 == 3'b010);
            ctrl_d.regwrite    = 1'b1;
            ctrl_d.resultsrc   = ResultMem;
            ctrl_d.alusrc      = 1'b1;
            ctrl_d.alucontrol  = AluAdd;
         end
         OpStore: begin
            legal              = (funct3 == 3'b010);
            ctrl_d.memwrite    = 1'b1;
            ctrl_d.alusrc      = 1'b1;
            ctrl_d.alucontrol  = AluAdd;
            immsrc             = ImmS;
         end
         OpRType: begin
            ctrl_d.regwrite = 1'b1;
            if (funct7 == 7'b0000000) begin
               legal             = alu_f3[3];
               ctrl_d.alucontrol = alu_f3[2:0];
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               ctrl_d.alucontrol = AluSub;
            end else begin
               legal = 1'b0;
            end
         end
         OpIAlu: begin
            legal              = alu_f3[3];
            ctrl_d.regwrite    = 1'b1;
            ctrl_d.alusrc      = 1'b1;
            ctrl_d.alucontrol  = alu_f3[2:0];
         end
         OpBranch: begin
            legal              = (funct3 == 3'b000);
            ctrl_d.branch      = 1'b1;
            ctrl_d.alucontrol  = AluSub;
            immsrc             = ImmB;
         end
         OpJal: begin
            ctrl_d.regwrite    = 1'b1;
            ctrl_d.jump        = 1'b1;
            ctrl_d.resultsrc   = ResultPc4;
            immsrc             = ImmJ;
         end
         default: legal = 1'b0;
      endcase
      // Illegal is the bubble encoding with only the flag set.
      if (!legal) begin
         ctrl_d         = '0;
         ctrl_d.illegal = 1'b1;
      end
   end

   assign immext_d = XLEN'(imm_ext(instrD, immsrc));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         immext_q  <= '0;
         pc_q      <= '0;
         pcincr4_q <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
      end else begin
         ctrl_q    <= flushE ? '0 : ctrl_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         immext_q  <= immext_d;
         pc_q      <= pcD;
         pcincr4_q <= pcincr4D;
         rs1_q     <= rs1D;
         rs2_q     <= rs2D;
         rd_q      <= instrD[11:7];
      end
   end

   assign rd1E        = rd1_q;
   assign rd2E        = rd2_q;
   assign immextE     = immext_q;
   assign pcE         = pc_q;
   assign pcincr4E    = pcincr4_q;
   assign rs1E        = rs1_q;
   assign rs2E        = rs2_q;
   assign rdE         = rd_q;
   assign regwriteE   = ctrl_q.regwrite;
   assign resultsrcE  = ctrl_q.resultsrc;
   assign memwriteE   = ctrl_q.memwrite;
   assign jumpE       = ctrl_q.jump;
   assign branchE     = ctrl_q.branch;
   assign alusrcE     = ctrl_q.alusrc;
   assign alucontrolE = ctrl_q.alucontrol;
   assign illegalE    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed and randomized checks of decode_cycle against an instruction-level
// reference model (register array plus per-opcode decode table).
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instrD, pcD, pcincr4D, resultW;
   logic        regwriteW, flushE;
   logic [4:0]  rdW;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE;
   logic [31:0] rd1E, rd2E, immextE, pcE, pcincr4E;
   logic        regwriteE, memwriteE, jumpE, branchE, alusrcE, illegalE;
   logic [1:0]  resultsrcE;
   logic [2:0]  alucontrolE;

   int n_checks = 0;
   int n_errs   = 0;
   logic [31:0] m_rf [32];

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instrD      (instrD),
      .pcD         (pcD),
      .pcincr4D    (pcincr4D),
      .regwriteW   (regwriteW),
      .rdW         (rdW),
      .resultW     (resultW),
      .flushE      (flushE),
      .rs1D        (rs1D),
      .rs2D        (rs2D),
      .rd1E        (rd1E),
      .rd2E        (rd2E),
      .immextE     (immextE),
      .pcE         (pcE),
      .pcincr4E    (pcincr4E),
      .rs1E        (rs1E),
      .rs2E        (rs2E),
      .rdE         (rdE),
      .regwriteE   (regwriteE),
      .resultsrcE  (resultsrcE),
      .memwriteE   (memwriteE),
      .jumpE       (jumpE),
      .branchE     (branchE),
      .alusrcE     (alusrcE),
      .alucontrolE (alucontrolE),
      .illegalE    (illegalE)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Arithmetic immediate extraction, written independently of bit concatenation.
   function automatic logic [31:0] sx(input logic [31:0] instr, input int unsigned top_bit);
      return instr[31] ? (32'hFFFF_FFFF << top_bit) : 32'd0;
   endfunction

   function automatic int alu_code(input logic [2:0] f3);
      if (f3 == 3'd0) return 0;
      if (f3 == 3'd7) return 2;
      if (f3 == 3'd6) return 3;
      if (f3 == 3'd2) return 5;
      return -1;
   endfunction

   task automatic step(input logic [31:0] instr, input logic rstn, input logic flush,
                       input logic rw, input logic [4:0] rdw, input logic [31:0] res);
      logic [31:0] pc, e_imm, e_rd1, e_rd2;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          ac;
      logic        ok, e_rw, e_mw, e_j, e_b, e_as, e_il, imm_used;
      logic [1:0]  e_rs;
      logic [2:0]  e_ac;

      pc = $urandom;
      @(negedge clk);
      instrD = instr; pcD = pc; pcincr4D = pc + 32'd4;
      rst_n = rstn; flushE = flush; regwriteW = rw; rdW = rdw; resultW = res;
      #1;
      check_val("rs1D", 32'(rs1D), (instr >> 15) & 32'h1F);
      check_val("rs2D", 32'(rs2D), (instr >> 20) & 32'h1F);

      op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
      ok = 1'b0; e_rw = 0; e_mw = 0; e_j = 0; e_b = 0; e_as = 0; e_rs = 0; e_ac = 0;
      imm_used = 1'b0; e_imm = 0;
      if (op == 7'h03 && f3 == 3'd2) begin
         ok = 1; e_rw = 1; e_rs = 2'd1; e_as = 1; imm_used = 1;
         e_imm = sx(instr, 12) | (instr >> 20);
      end else if (op == 7'h23 && f3 == 3'd2) begin
         ok = 1; e_mw = 1; e_as = 1; imm_used = 1;
         e_imm = sx(instr, 12) | (((instr >> 25) & 32'h7F) << 5) | ((instr >> 7) & 32'h1F);
      end else if (op == 7'h33) begin
         ac = alu_code(f3);
         if (f7 == 7'h00 && ac >= 0) begin ok = 1; e_ac = 3'(ac); end
         else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e_ac = 3'd1; end
         e_rw = 1;
      end else if (op == 7'h13) begin
         ac = alu_code(f3);
         if (ac >= 0) begin ok = 1; e_ac = 3'(ac); end
         e_rw = 1; e_as = 1; imm_used = 1;
         e_imm = sx(instr, 12) | (instr >> 20);
      end else if (op == 7'h63 && f3 == 3'd0) begin
         ok = 1; e_b = 1; e_ac = 3'd1; imm_used = 1;
         e_imm = sx(instr, 12) | (((instr >> 7) & 32'h1) << 11)
               | (((instr >> 25) & 32'h3F) << 5) | (((instr >> 8) & 32'hF) << 1);
      end else if (op == 7'h6F) begin
         ok = 1; e_rw = 1; e_j = 1; e_rs = 2'd2; imm_used = 1;
         e_imm = sx(instr, 20) | (instr & 32'h000F_F000) | (((instr >> 20) & 32'h1) << 11)
               | (((instr >> 21) & 32'h3FF) << 1);
      end
      e_il = ~ok;
      if (!ok) begin e_rw = 0; e_mw = 0; e_j = 0; e_b = 0; e_as = 0; e_rs = 0; e_ac = 0; end
      if (flush || !rstn) begin
         e_rw = 0; e_mw = 0; e_j = 0; e_b = 0; e_as = 0; e_rs = 0; e_ac = 0; e_il = 0;
      end

      if (!rstn) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else if (rw && rdw != 5'd0) begin
         m_rf[rdw] = res;
      end
      e_rd1 = m_rf[instr[19:15]];
      e_rd2 = m_rf[instr[24:20]];

      @(posedge clk);
      #1;
      check_val("regwriteE", 32'(regwriteE), 32'(e_rw));
      check_val("resultsrcE", 32'(resultsrcE), 32'(e_rs));
      check_val("memwriteE", 32'(memwriteE), 32'(e_mw));
      check_val("jumpE", 32'(jumpE), 32'(e_j));
      check_val("branchE", 32'(branchE), 32'(e_b));
      check_val("alusrcE", 32'(alusrcE), 32'(e_as));
      check_val("alucontrolE", 32'(alucontrolE), 32'(e_ac));
      check_val("illegalE", 32'(illegalE), 32'(e_il));
      if (!rstn) begin
         check_val("rst_rd1E", rd1E, 32'd0);
         check_val("rst_rd2E", rd2E, 32'd0);
         check_val("rst_immextE", immextE, 32'd0);
         check_val("rst_pcE", pcE, 32'd0);
         check_val("rst_pcincr4E", pcincr4E, 32'd0);
         check_val("rst_idx", {17'd0, rs1E, rs2E, rdE}, 32'd0);
      end else if (!flush) begin
         check_val("rd1E", rd1E, e_rd1);
         check_val("rd2E", rd2E, e_rd2);
         check_val("pcE", pcE, pc);
         check_val("pcincr4E", pcincr4E, pc + 32'd4);
         check_val("rs1E", 32'(rs1E), 32'(instr[19:15]));
         check_val("rs2E", 32'(rs2E), 32'(instr[24:20]));
         check_val("rdE", 32'(rdE), 32'(instr[11:7]));
         if (ok && imm_used) check_val("immextE", immextE, e_imm);
      end
   endtask

   initial begin
      logic [31:0] instr;
      logic [6:0]  ops [7];
      ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
      ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h7F;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      rst_n = 1'b0; instrD = '0; pcD = '0; pcincr4D = '0;
      regwriteW = 1'b0; rdW = '0; resultW = '0; flushE = 1'b0;

      // Reset with random fetch data and a concurrent write that must be ignored.
      step($urandom, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234_5678);
      step($urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step(32'h0002_80B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("reset_x5", rd1E, 32'd0);

      step(32'h0000_0013, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      step(32'h0052_83B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("wb_rd1E", rd1E, 32'hDEAD_BEEF);
      check_val("wb_rd2E", rd2E, 32'hDEAD_BEEF);
      check_val("wb_rdE", 32'(rdE), 32'd7);

      step(32'hFFC2_A103, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0100);
      check_val("byp_rd1E", rd1E, 32'h0000_0100);
      check_val("byp_imm", immextE, 32'hFFFF_FFFC);
      check_val("byp_resultsrc", 32'(resultsrcE), 32'd1);

      step(32'h0000_00B3, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0055);
      check_val("x0_bypass", rd1E, 32'd0);
      step(32'h0000_00B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("x0_read", rd1E, 32'd0);

      step(32'h0061_2423, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      check_val("flush_memwrite", 32'(memwriteE), 32'd0);
      step(32'h0061_2423, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("sw_memwrite", 32'(memwriteE), 32'd1);
      check_val("sw_imm", immextE, 32'd8);

      step(32'hFE20_8CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("beq_imm", immextE, 32'hFFFF_FFF8);
      step(32'h0100_00EF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("jal_imm", immextE, 32'h0000_0010);
      step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("ill_flag", 32'(illegalE), 32'd1);
      step(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check_val("zero_illegal", 32'(illegalE), 32'd1);

      for (int n = 0; n < 400; n++) begin
         instr = $urandom;
         instr[6:0] = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 1) == 1) begin
            instr[14:12] = 3'($urandom_range(0, 1) == 1 ? 0 : 2);
            instr[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
         end
         if ($urandom_range(0, 1) == 1) begin
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
         end
         step(instr, ($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
